// File: rtl/spi_sck_gen_if.sv
// spi_sck_gen_if: control and strobe bundle between the
// SPI master control FSM and the SCK burst generator.
interface spi_sck_gen_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 6
);

  logic             start;
  logic             abort;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] nbits;
  logic             cpol;
  logic             cpha;
  logic             sck;
  logic             busy;
  logic             done;
  logic             sample_tick;
  logic             shift_tick;

  modport master (
    output start,
    output abort,
    output div,
    output nbits,
    output cpol,
    output cpha,
    input  sck,
    input  busy,
    input  done,
    input  sample_tick,
    input  shift_tick
  );

  modport slave (
    input  start,
    input  abort,
    input  div,
    input  nbits,
    input  cpol,
    input  cpha,
    output sck,
    output busy,
    output done,
    output sample_tick,
    output shift_tick
  );

endinterface

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: programmable SCK burst generator with
// CPOL/CPHA, sample/shift strobes and start/busy/done.
module spi_sck_gen #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          rst_n,
  spi_sck_gen_if.slave bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] div_nx;
  logic [CNT_W-1:0] nbits_l;
  logic [CNT_W-1:0] nbits_nx;
  logic             cpol_l;
  logic             cpol_nx;
  logic             cpha_l;
  logic             cpha_nx;

  logic [DIV_W-1:0] hc;
  logic [DIV_W-1:0] hc_nx;
  logic [CNT_W:0]   e;
  logic [CNT_W:0]   e_nx;

  logic             sck_q;
  logic             sck_nx;
  logic             busy_q;
  logic             busy_nx;
  logic             done_q;
  logic             done_nx;
  logic             smp_q;
  logic             smp_nx;
  logic             shf_q;
  logic             shf_nx;

  // Index of the final edge: 2*(nbits+1)-1, one bit
  // wider than nbits so it never wraps.
  logic [CNT_W:0]   last;
  logic             lead;

  assign last = {nbits_l, 1'b1};
  assign lead = ~e[0];

  // State, latched configuration, counters and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_l   <= '0;
      nbits_l <= '0;
      cpol_l  <= 1'b0;
      cpha_l  <= 1'b0;
      hc      <= '0;
      e       <= '0;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      smp_q   <= 1'b0;
      shf_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      div_l   <= div_nx;
      nbits_l <= nbits_nx;
      cpol_l  <= cpol_nx;
      cpha_l  <= cpha_nx;
      hc      <= hc_nx;
      e       <= e_nx;
      sck_q   <= sck_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      smp_q   <= smp_nx;
      shf_q   <= shf_nx;
    end
  end

  // Next-state: accept start in IDLE, walk half-periods
  // and edges in RUN, abort overriding everything.
  always_comb begin
    state_nx = state;
    div_nx   = div_l;
    nbits_nx = nbits_l;
    cpol_nx  = cpol_l;
    cpha_nx  = cpha_l;
    hc_nx    = hc;
    e_nx     = e;
    sck_nx   = sck_q;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    smp_nx   = 1'b0;
    shf_nx   = 1'b0;

    unique case (state)
      IDLE: begin
        sck_nx  = bus.cpol;
        busy_nx = 1'b0;
        if (bus.start && !bus.abort) begin
          div_nx   = bus.div;
          nbits_nx = bus.nbits;
          cpol_nx  = bus.cpol;
          cpha_nx  = bus.cpha;
          hc_nx    = '0;
          e_nx     = '0;
          busy_nx  = 1'b1;
          state_nx = RUN;
        end
      end

      RUN: begin
        if (bus.abort) begin
          sck_nx   = cpol_l;
          busy_nx  = 1'b0;
          hc_nx    = '0;
          e_nx     = '0;
          state_nx = IDLE;
        end else if (hc == div_l) begin
          hc_nx  = '0;
          sck_nx = ~sck_q;
          e_nx   = e + 1'b1;
          smp_nx = cpha_l ? ~lead : lead;
          if (cpha_l) begin
            shf_nx = lead && (e != '0);
          end else begin
            shf_nx = !lead && (e != last);
          end
          if (e == last) begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end
        end else begin
          hc_nx = hc + 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.sck         = sck_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.sample_tick = smp_q;
  assign bus.shift_tick  = shf_q;

endmodule

// File: tb/tb_spi_sck_gen.sv
// tb_spi_sck_gen: directed bursts on a default instance
// and a CNT_W=3 instance, checked against hand values.
module tb_spi_sck_gen;

  logic clk;
  logic rst_n;

  spi_sck_gen_if #(.DIV_W(16), .CNT_W(6)) b ();
  spi_sck_gen_if #(.DIV_W(16), .CNT_W(3)) b3 ();

  spi_sck_gen #(.DIV_W(16), .CNT_W(6)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  spi_sck_gen #(.DIV_W(16), .CNT_W(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic sel3;
  logic m_sck;
  logic m_busy;
  logic m_done;
  logic m_smp;
  logic m_shf;

  assign m_sck  = sel3 ? b3.sck : b.sck;
  assign m_busy = sel3 ? b3.busy : b.busy;
  assign m_done = sel3 ? b3.done : b.done;
  assign m_smp  = sel3 ? b3.sample_tick : b.sample_tick;
  assign m_shf  = sel3 ? b3.shift_tick : b.shift_tick;

  int   cyc;
  int   busy_n;
  int   smp_n;
  int   shf_n;
  int   tog_n;
  int   first_tog;
  int   last_tog;
  int   first_smp;
  int   done_at;
  int   phase_bad;
  logic prev_sck;
  logic smp_lvl;
  logic shf_lvl;

  task automatic chk(input string tag, input int got,
                     input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    cyc       = 0;
    busy_n    = 0;
    smp_n     = 0;
    shf_n     = 0;
    tog_n     = 0;
    first_tog = -1;
    last_tog  = -1;
    first_smp = -1;
    done_at   = -1;
    phase_bad = 0;
    prev_sck  = m_sck;
  endtask

  // One clock; sample 1 ns after the edge.
  // cyc==k means spec cycle T+k.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (m_busy) busy_n++;
    if (m_sck != prev_sck) begin
      tog_n++;
      if (first_tog < 0) first_tog = cyc;
      last_tog = cyc;
    end
    if (m_smp) begin
      smp_n++;
      if (first_smp < 0) first_smp = cyc;
      if (m_sck != smp_lvl) phase_bad++;
    end
    if (m_shf) begin
      shf_n++;
      if (m_sck != shf_lvl) phase_bad++;
    end
    if (m_done && done_at < 0) done_at = cyc;
    prev_sck = m_sck;
  endtask

  task automatic run_until_done(input int bound);
    while (done_at < 0 && cyc < bound) step();
  endtask

  task automatic drive(input logic s3, input int d,
                       input int n, input logic pol,
                       input logic pha);
    logic [31:0] nv;
    nv = n;
    if (s3) begin
      b3.div   = d[15:0];
      b3.nbits = nv[2:0];
      b3.cpol  = pol;
      b3.cpha  = pha;
    end else begin
      b.div   = d[15:0];
      b.nbits = nv[5:0];
      b.cpol  = pol;
      b.cpha  = pha;
    end
  endtask

  // One idle cycle so sck settles at cpol, then start
  // is sampled at edge T.
  task automatic launch(input logic s3, input int d,
                        input int n, input logic pol,
                        input logic pha, input logic hold);
    sel3 = s3;
    drive(s3, d, n, pol, pha);
    smp_lvl = pha ? pol : ~pol;
    shf_lvl = ~smp_lvl;
    @(posedge clk);
    #1;
    if (s3) b3.start = 1'b1;
    else    b.start  = 1'b1;
    clr();
    step();
    if (!hold) begin
      b.start  = 1'b0;
      b3.start = 1'b0;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sel3  = 1'b0;
    rst_n = 1'b0;
    b.start  = 1'b0;
    b.abort  = 1'b0;
    b3.start = 1'b0;
    b3.abort = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 0, 0, 1'b0, 1'b0);
    smp_lvl = 1'b1;
    shf_lvl = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("rst_sck", b.sck, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_done", b.done, 0);
    chk("rst_smp", b.sample_tick, 0);
    chk("rst_shf", b.shift_tick, 0);
    chk("rst_busy3", b3.busy, 0);
    rst_n = 1'b1;

    // abort in IDLE blocks start
    b.start = 1'b1;
    b.abort = 1'b1;
    @(posedge clk);
    #1;
    b.start = 1'b0;
    b.abort = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_abort_busy", b.busy, 0);

    // div=0 nbits=7 mode 0
    launch(1'b0, 0, 7, 1'b0, 1'b0, 1'b0);
    chk("t1_busy_T1", m_busy, 1);
    run_until_done(60);
    chk("t1_done_at", done_at, 17);
    chk("t1_busy_n", busy_n, 16);
    chk("t1_tog_n", tog_n, 16);
    chk("t1_first_tog", first_tog, 2);
    chk("t1_smp_n", smp_n, 8);
    chk("t1_shf_n", shf_n, 7);
    chk("t1_phase", phase_bad, 0);
    chk("t1_busy_end", m_busy, 0);
    chk("t1_sck_end", m_sck, 0);

    // div=3 nbits=0 cpol=1 cpha=1
    launch(1'b0, 3, 0, 1'b1, 1'b1, 1'b0);
    chk("t2_idle_sck", prev_sck, 1);
    run_until_done(60);
    chk("t2_first_tog", first_tog, 5);
    chk("t2_last_tog", last_tog, 9);
    chk("t2_tog_n", tog_n, 2);
    chk("t2_smp_n", smp_n, 1);
    chk("t2_smp_at", first_smp, 9);
    chk("t2_shf_n", shf_n, 0);
    chk("t2_done_at", done_at, 9);
    chk("t2_busy_n", busy_n, 8);
    chk("t2_phase", phase_bad, 0);

    // CNT_W=3, nbits=7, div=1: full edge range
    launch(1'b1, 1, 7, 1'b0, 1'b0, 1'b0);
    run_until_done(80);
    chk("t3_done_at", done_at, 33);
    chk("t3_tog_n", tog_n, 16);
    chk("t3_smp_n", smp_n, 8);
    chk("t3_shf_n", shf_n, 7);
    chk("t3_busy_n", busy_n, 32);
    chk("t3_phase", phase_bad, 0);
    repeat (4) step();
    chk("t3_no_rerun", tog_n, 16);
    sel3 = 1'b0;

    // abort on the final edge: div=0 nbits=1
    launch(1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
    while (cyc < 4) step();
    b.abort = 1'b1;
    step();
    b.abort = 1'b0;
    chk("t4_busy", m_busy, 0);
    chk("t4_sck", m_sck, 0);
    chk("t4_done", m_done, 0);
    chk("t4_smp", m_smp, 0);
    chk("t4_shf", m_shf, 0);
    repeat (4) step();
    chk("t4_done_never", done_at, -1);
    chk("t4_smp_n", smp_n, 2);
    chk("t4_shf_n", shf_n, 1);

    // abort in place of edge 5: div=1 nbits=7 cpol=1
    launch(1'b0, 1, 7, 1'b1, 1'b0, 1'b0);
    while (cyc < 12) step();
    b.abort = 1'b1;
    step();
    b.abort = 1'b0;
    chk("t5_busy", m_busy, 0);
    chk("t5_sck", m_sck, 1);
    chk("t5_done", m_done, 0);
    repeat (10) step();
    chk("t5_tog_n", tog_n, 6);
    chk("t5_busy_n", busy_n, 12);
    chk("t5_smp_n", smp_n, 3);
    chk("t5_shf_n", shf_n, 2);
    chk("t5_done_never", done_at, -1);

    // start held through busy, cpol/div changed mid-burst,
    // back-to-back restart in the done cycle
    launch(1'b0, 0, 3, 1'b0, 1'b0, 1'b1);
    b.div  = 16'd2;
    b.cpol = 1'b1;
    run_until_done(40);
    chk("t6_done_at", done_at, 9);
    chk("t6_busy_n", busy_n, 8);
    chk("t6_tog_n", tog_n, 8);
    chk("t6_sck_end", m_sck, 0);
    chk("t6_phase", phase_bad, 0);
    busy_n  = 0;
    done_at = -1;
    smp_lvl = 1'b0;
    shf_lvl = 1'b1;
    step();
    b.start = 1'b0;
    chk("t6_b2b_busy", m_busy, 1);
    chk("t6_b2b_sck", m_sck, 1);
    first_tog = -1;
    smp_n     = 0;
    shf_n     = 0;
    phase_bad = 0;
    run_until_done(80);
    chk("t6_b2b_first", first_tog, 13);
    chk("t6_b2b_done", done_at, 34);
    chk("t6_b2b_busy_n", busy_n, 24);
    chk("t6_b2b_smp_n", smp_n, 4);
    chk("t6_b2b_shf_n", shf_n, 3);
    chk("t6_b2b_phase", phase_bad, 0);
    chk("t6_b2b_sck_end", m_sck, 1);

    // reset in place of edge 3
    launch(1'b0, 1, 7, 1'b1, 1'b1, 1'b0);
    while (cyc < 8) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t7_sck", m_sck, 0);
    chk("t7_busy", m_busy, 0);
    chk("t7_done", m_done, 0);
    repeat (30) step();
    chk("t7_done_never", done_at, -1);
    chk("t7_busy_after", m_busy, 0);
    chk("t7_sck_idle", m_sck, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
